// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences PC load/count/branch commands, issues one
// memory read at a time and buffers returned words in a small FIFO for decode.
module fetch_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              boot_hi,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_load,
  output logic              pc_start_hi,
  output logic              pc_count,
  output logic              pc_branch,
  output logic [1:0]        pc_add_amt,
  input  logic              br_valid,
  input  logic [1:0]        br_amt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] REQ  = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  logic [1:0]        state, state_nx;
  logic              discard, discard_nx;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              flush, push, pop, fire_req, take_br, take_cnt, do_load, head_valid;

  assign head_valid = (count != '0);

  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    flush      = 1'b0;
    push       = 1'b0;
    fire_req   = 1'b0;
    take_br    = 1'b0;
    take_cnt   = 1'b0;
    do_load    = 1'b0;
    case (state)
      IDLE: if (run) state_nx = LOAD;
      LOAD: begin
        do_load  = 1'b1;
        flush    = 1'b1;
        state_nx = REQ;
      end
      REQ: begin
        if (!run) begin
          state_nx = IDLE;
        end else if (br_valid) begin
          take_br = 1'b1;
          flush   = 1'b1;
        end else if (count < CNT_W'(DEPTH)) begin
          fire_req = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // A redirect beats a coincident ack; without an ack the in-flight word is marked stale.
        if (br_valid) begin
          take_br = 1'b1;
          flush   = 1'b1;
          if (mem_ack) begin
            discard_nx = 1'b0;
            state_nx   = REQ;
          end else begin
            discard_nx = 1'b1;
          end
        end else if (mem_ack) begin
          discard_nx = 1'b0;
          if (!discard) begin
            push     = 1'b1;
            take_cnt = 1'b1;
          end
          state_nx = run ? REQ : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop = head_valid & inst_ready & ~flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      discard  <= 1'b0;
      req_addr <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;
      if (fire_req) req_addr <= pc;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      data_mem[wr_ptr] <= mem_rdata;
    end
  end

  // Commands are held low while reset is asserted so the PC never sees a stale pulse.
  assign pc_load     = do_load & ~reset;
  assign pc_start_hi = pc_load & boot_hi;
  assign pc_count    = take_cnt & ~reset;
  assign pc_branch   = take_br & ~reset;
  assign pc_add_amt  = pc_branch ? br_amt : '0;
  assign mem_req     = fire_req & ~reset;
  assign mem_addr    = mem_req ? pc : '0;
  assign inst_valid  = head_valid & ~reset;
  assign inst_data   = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_addr   = inst_valid ? addr_mem[rd_ptr] : '0;
  assign busy        = (state != IDLE) & ~reset;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: PC and memory environment models, a queue-based
// reference of the expected instruction stream, directed scenarios then random traffic.
module tb_fetch_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  logic              clock = 1'b0;
  logic              reset, run, boot_hi, br_valid, inst_ready, mem_ack;
  logic [1:0]        br_amt, pc_add_amt;
  logic [ADDR_W-1:0] pc, mem_addr, inst_addr;
  logic [DATA_W-1:0] mem_rdata, inst_data;
  logic              pc_load, pc_start_hi, pc_count, pc_branch, mem_req, inst_valid, busy;

  fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .run(run), .boot_hi(boot_hi), .pc(pc),
    .pc_load(pc_load), .pc_start_hi(pc_start_hi), .pc_count(pc_count),
    .pc_branch(pc_branch), .pc_add_amt(pc_add_amt), .br_valid(br_valid), .br_amt(br_amt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_addr(inst_addr), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic [DATA_W-1:0] words [64];
  ent_t q[$];
  int   vectors = 0, miscompares = 0;
  int   n_pop = 0, n_req = 0;
  int   lat = 1;
  bit   rand_lat = 0;
  bit   req_flag = 0;
  logic [ADDR_W-1:0] req_a = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program counter seen by the DUT: load, +4 per count, +4*amt per branch.
  always @(posedge clock) begin
    if (reset)          pc <= '0;
    else if (pc_load)   pc <= pc_start_hi ? 6'd32 : 6'd0;
    else if (pc_count)  pc <= pc + 6'd4;
    else if (pc_branch) pc <= pc + {2'b00, pc_add_amt, 2'b00};
  end

  // Memory: answers each request after lat cycles, regardless of reset.
  bit pend = 0;
  int pcnt = 0;
  logic [ADDR_W-1:0] paddr = '0;
  always @(posedge clock) begin
    if (req_flag) begin
      pend  = 1;
      paddr = req_a;
      pcnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
    end
    #1;
    mem_ack   = 1'b0;
    mem_rdata = DATA_W'($urandom);
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = words[paddr];
        pend      = 0;
      end
    end
  end

  // Reference model and monitor, sampled on the falling edge.
  int   ph = 0;
  int   exp_pc = 0;
  bit   outst = 0, drop = 0, prev_rst = 0;
  always @(negedge clock) begin : monitor
    bit e_br, e_cnt, e_req, e_pop;
    int ph0;
    req_flag = mem_req;
    req_a    = mem_addr;
    if (mem_req) n_req++;
    if (prev_rst)
      check("reset_outputs",
            {pc_load, pc_start_hi, pc_count, pc_branch, pc_add_amt, mem_req, mem_addr,
             inst_valid, inst_data, inst_addr, busy}, 64'd0);
    prev_rst = reset;
    if (reset) begin
      q.delete();
      ph = 0; outst = 0; drop = 0;
    end else begin
      e_br  = (ph == 2) && br_valid && (outst || run);
      e_cnt = (ph == 2) && outst && mem_ack && !br_valid && !drop;
      e_req = (ph == 2) && !outst && run && !br_valid && (q.size() < DEPTH);
      check("busy", busy, ph != 0);
      check("pc_load", {pc_load, pc_start_hi}, {ph == 1, (ph == 1) && boot_hi});
      check("pc_count", pc_count, e_cnt);
      check("pc_branch", {pc_branch, pc_add_amt}, {e_br, e_br ? br_amt : 2'b00});
      check("mem_req", mem_req, e_req);
      if (e_req) check("mem_addr", mem_addr, exp_pc);
      check("inst_valid", inst_valid, q.size() != 0);
      if (q.size() != 0) check("inst_word", {inst_addr, inst_data}, {q[0].addr, q[0].data});
      e_pop = (q.size() != 0) && inst_ready && !e_br && (ph != 1);
      if (e_pop) begin
        void'(q.pop_front());
        n_pop++;
      end
      ph0 = ph;
      case (ph0)
        0: if (run) ph = 1;
        1: begin
          q.delete();
          exp_pc = boot_hi ? 32 : 0;
          ph = 2;
        end
        default: begin
          if (e_br) begin
            q.delete();
            exp_pc = (exp_pc + 4 * int'(br_amt)) & 63;
            if (outst) begin
              if (mem_ack) begin outst = 0; drop = 0; end
              else drop = 1;
            end
          end else if (outst) begin
            if (mem_ack) begin
              if (!drop) begin
                q.push_back('{addr: ADDR_W'(exp_pc), data: words[exp_pc]});
                exp_pc = (exp_pc + 4) & 63;
              end
              drop = 0; outst = 0;
              if (!run) ph = 0;
            end
          end else if (!run) ph = 0;
          else if (e_req) outst = 1;
        end
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; br_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_req && n < 50);
    check("wait_req_timeout", mem_req, 1'b1);
  endtask

  initial begin
    int p0, r0;
    for (int i = 0; i < 64; i++) words[i] = DATA_W'($urandom);
    reset = 1'b1; run = 1'b0; boot_hi = 1'b0; br_valid = 1'b0; br_amt = 2'd0;
    inst_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    cyc(1);

    // boot from 0, fast memory, free-flowing decode
    do_reset(); boot_hi = 1'b0; inst_ready = 1'b1; lat = 1; p0 = n_pop;
    run = 1'b1; cyc(30);
    check("boot0_throughput", n_pop - p0 >= 8, 1'b1);
    run = 1'b0; cyc(8);

    // boot from 32
    do_reset(); boot_hi = 1'b1; p0 = n_pop;
    run = 1'b1; cyc(20);
    check("boot32_throughput", n_pop - p0 >= 4, 1'b1);
    run = 1'b0; cyc(8);

    // backpressure: FIFO fills, then one pop admits one more fetch
    do_reset(); boot_hi = 1'b0; inst_ready = 1'b0; lat = 3; r0 = n_req;
    run = 1'b1; cyc(25);
    check("bp_reqs_full", n_req - r0, 2);
    inst_ready = 1'b1; cyc(1); inst_ready = 1'b0; cyc(15);
    check("bp_reqs_after_pop", n_req - r0, 3);
    run = 1'b0; inst_ready = 1'b1; cyc(10);

    // branch two cycles before the ack
    do_reset(); lat = 4; run = 1'b1;
    wait_req();
    @(posedge clock); @(posedge clock); #1;
    br_valid = 1'b1; br_amt = 2'd3;
    cyc(1); br_valid = 1'b0;
    cyc(20); run = 1'b0; cyc(10);

    // branch coincident with the ack
    do_reset(); lat = 2; run = 1'b1;
    wait_req();
    @(posedge clock); @(posedge clock); #1;
    br_valid = 1'b1; br_amt = 2'd2;
    cyc(1); br_valid = 1'b0;
    cyc(20); run = 1'b0; cyc(10);

    // reset while waiting; ack lands one cycle later
    do_reset(); lat = 2; run = 1'b1;
    wait_req();
    @(posedge clock); #1;
    reset = 1'b1; run = 1'b0;
    cyc(1); reset = 1'b0;
    cyc(6);

    // random traffic
    do_reset(); rand_lat = 1; run = 1'b1; p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      inst_ready = 1'($urandom);
      br_valid   = ($urandom_range(0, 11) == 0);
      br_amt     = 2'($urandom);
      boot_hi    = 1'($urandom);
      reset      = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    check("random_progress", n_pop - p0 > 50, 1'b1);
    reset = 1'b0; run = 1'b0; br_valid = 1'b0; cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
